// File: rtl/scrambler_tx_sequencer.sv
// Transmit-side source selector for scrambler_top (8b/10b, 4 symbols per word).
// Chooses, every cycle, between TS1 ordered sets, periodic SKP ordered sets and
// link-layer data / logical idle, and generates the matching scramble_enable
// and per-symbol training_sequence bypass flags. Byte 0 is first on the wire.
//
// state  | meaning
// S_IDLE | link off: all-zero output, SKP timer and request held cleared
// S_TS   | training: TS1 words w0..w3, SKP inserted only ahead of w0
// S_DATA | data mode: link-layer words or logical idle, SKP has priority
module scrambler_tx_sequencer #(
  parameter int unsigned SKP_INTERVAL = 295,
  parameter logic [7:0]  N_FTS        = 8'h80,
  parameter logic [7:0]  RATE_ID      = 8'h02
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  mode_i,
  input  logic        scr_disable_i,
  input  logic [31:0] tx_data_i,
  input  logic [3:0]  tx_datak_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [31:0] indata_o,
  output logic [3:0]  datak_o,
  output logic [1:0]  data_len_o,
  output logic        scramble_enable_o,
  output logic [3:0]  training_sequence_o,
  output logic        skp_overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TS   = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_TRAIN = 2'b01;
  localparam logic [1:0]  MODE_DATA  = 2'b10;
  localparam logic [11:0] SKP_LAST   = 12'(SKP_INTERVAL - 1);
  localparam logic [31:0] SKP_WORD   = 32'h1C1C1CBC;
  localparam logic [31:0] TS1_W0     = {N_FTS, 8'hF7, 8'hF7, 8'hBC};
  localparam logic [31:0] TS1_W1     = {8'h4A, 8'h4A, 8'h00, RATE_ID};
  localparam logic [31:0] TS1_W23    = 32'h4A4A4A4A;

  state_t      state_q, state_d;
  logic [1:0]  ts_idx_q, ts_idx_d;
  logic [11:0] skp_cnt_q, skp_cnt_d;
  logic        skp_pending_q, skp_pending_d;
  logic [31:0] indata_q, indata_d;
  logic [3:0]  datak_q, datak_d;
  logic [3:0]  ts_q, ts_d;
  logic        scr_en_q, scr_en_d;
  logic        overrun_q, overrun_d;
  logic        skp_take;
  logic        skp_wrap;

  // Data is only accepted in data mode when no SKP is waiting to go out.
  assign tx_ready_o          = (state_q == S_DATA) && !skp_pending_q;
  assign data_len_o          = 2'b10;
  assign indata_o            = indata_q;
  assign datak_o             = datak_q;
  assign training_sequence_o = ts_q;
  assign scramble_enable_o   = scr_en_q;
  assign skp_overrun_o       = overrun_q;

  // Next-state, source selection and SKP scheduling.
  always_comb begin
    state_d       = state_q;
    ts_idx_d      = ts_idx_q;
    skp_cnt_d     = skp_cnt_q;
    skp_pending_d = skp_pending_q;
    indata_d      = 32'h0;
    datak_d       = 4'b0000;
    ts_d          = 4'b0000;
    scr_en_d      = 1'b0;
    overrun_d     = 1'b0;
    skp_take      = 1'b0;
    skp_wrap      = (state_q != S_IDLE) && (skp_cnt_q == SKP_LAST);

    case (state_q)
      S_IDLE: begin
        ts_idx_d = 2'd0;
        if (mode_i == MODE_TRAIN)     state_d = S_TS;
        else if (mode_i == MODE_DATA) state_d = S_DATA;
      end

      S_TS: begin
        ts_d = 4'b1111;
        if (ts_idx_q == 2'd0 && skp_pending_q) begin
          skp_take = 1'b1;
          indata_d = SKP_WORD;
          datak_d  = 4'b1111;
        end else begin
          ts_idx_d = ts_idx_q + 2'd1;
          case (ts_idx_q)
            2'd0: begin
              indata_d = TS1_W0;
              datak_d  = 4'b0111;
            end
            2'd1:    indata_d = TS1_W1;
            default: indata_d = TS1_W23;
          endcase
          // Mode is only honoured on an ordered-set boundary.
          if (ts_idx_q == 2'd3) begin
            if (mode_i == MODE_TRAIN)     state_d = S_TS;
            else if (mode_i == MODE_DATA) state_d = S_DATA;
            else                          state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        scr_en_d = ~scr_disable_i;
        if (skp_pending_q) begin
          skp_take = 1'b1;
          indata_d = SKP_WORD;
          datak_d  = 4'b1111;
          ts_d     = 4'b1111;
        end else if (tx_valid_i) begin
          indata_d = tx_data_i;
          datak_d  = tx_datak_i;
        end
        if (mode_i == MODE_TRAIN) begin
          state_d  = S_TS;
          ts_idx_d = 2'd0;
        end else if (mode_i != MODE_DATA) begin
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        ts_idx_d = 2'd0;
      end
    endcase

    if (state_q == S_IDLE) begin
      skp_cnt_d     = 12'd0;
      skp_pending_d = 1'b0;
    end else begin
      skp_cnt_d = skp_wrap ? 12'd0 : skp_cnt_q + 12'd1;
      if (skp_take) skp_pending_d = 1'b0;
      // A wrap starts a new interval, so it wins over a same-cycle SKP send.
      if (skp_wrap) begin
        skp_pending_d = 1'b1;
        overrun_d     = skp_pending_q && !skp_take;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      ts_idx_q      <= 2'd0;
      skp_cnt_q     <= 12'd0;
      skp_pending_q <= 1'b0;
      indata_q      <= 32'h0;
      datak_q       <= 4'b0000;
      ts_q          <= 4'b0000;
      scr_en_q      <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ts_idx_q      <= ts_idx_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      indata_q      <= indata_d;
      datak_q       <= datak_d;
      ts_q          <= ts_d;
      scr_en_q      <= scr_en_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_scrambler_tx_sequencer.sv
// Directed bench for scrambler_tx_sequencer with default parameters.
module tb_scrambler_tx_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        scr_dis;
  logic [31:0] tx_data;
  logic [3:0]  tx_datak;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] indata;
  logic [3:0]  datak;
  logic [1:0]  data_len;
  logic        scr_en;
  logic [3:0]  ts;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] SKP  = 32'h1C1C1CBC;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic [31:0] ts_word [4];
  logic [3:0]  ts_k    [4];

  scrambler_tx_sequencer dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .mode_i              (mode),
    .scr_disable_i       (scr_dis),
    .tx_data_i           (tx_data),
    .tx_datak_i          (tx_datak),
    .tx_valid_i          (tx_valid),
    .tx_ready_o          (tx_ready),
    .indata_o            (indata),
    .datak_o             (datak),
    .data_len_o          (data_len),
    .scramble_enable_o   (scr_en),
    .training_sequence_o (ts),
    .skp_overrun_o       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic [3:0] k,
                         input logic [3:0] t, input logic en);
    chk({tag, "_data"}, indata, d);
    chk({tag, "_datak"}, {28'h0, datak}, {28'h0, k});
    chk({tag, "_ts"}, {28'h0, ts}, {28'h0, t});
    chk({tag, "_scren"}, {31'h0, scr_en}, {31'h0, en});
    chk({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
  endtask

  initial begin
    logic [31:0] nxt;
    logic [31:0] exp_word;
    logic        rdy;
    logic        exp_rdy;
    int          skp_obs;

    ts_word[0] = 32'h80F7F7BC; ts_k[0] = 4'b0111;
    ts_word[1] = 32'h4A4A0002; ts_k[1] = 4'b0000;
    ts_word[2] = 32'h4A4A4A4A; ts_k[2] = 4'b0000;
    ts_word[3] = 32'h4A4A4A4A; ts_k[3] = 4'b0000;

    rst = 1'b1; mode = 2'b00; scr_dis = 1'b0;
    tx_data = 32'h0; tx_datak = 4'h0; tx_valid = 1'b0;
    #2 rst = 1'b0;
    tick(); tick();
    chk_out("reset", 32'h0, 4'h0, 4'h0, 1'b0);
    chk("reset_ready", {31'h0, tx_ready}, 32'h0);
    chk("data_len", {30'h0, data_len}, 32'h2);

    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("idle", 32'h0, 4'h0, 4'h0, 1'b0);
      chk("idle_ready", {31'h0, tx_ready}, 32'h0);
    end

    // Training: first tick only moves IDLE -> TS.
    mode = 2'b01;
    tick();
    chk_out("ts_entry", 32'h0, 4'h0, 4'h0, 1'b0);
    for (int n = 1; n <= 296; n++) begin
      tick();
      chk_out("ts", ts_word[(n-1)%4], ts_k[(n-1)%4], 4'hF, 1'b0);
      chk("ts_ready", {31'h0, tx_ready}, 32'h0);
    end
    tick();
    chk_out("first_skp", SKP, 4'hF, 4'hF, 1'b0);
    tick();
    chk_out("ts_after_skp_w0", ts_word[0], ts_k[0], 4'hF, 1'b0);
    tick();
    chk_out("ts_after_skp_w1", ts_word[1], ts_k[1], 4'hF, 1'b0);
    // Switch to data while w1 is on the outputs; w2 and w3 must still follow.
    mode = 2'b10;
    tick();
    chk_out("ts_finish_w2", ts_word[2], ts_k[2], 4'hF, 1'b0);
    tick();
    chk_out("ts_finish_w3", ts_word[3], ts_k[3], 4'hF, 1'b0);

    // Continuous data; SKP expected at cycles 590, 885, 1180.
    nxt = BASE;
    exp_word = BASE;
    skp_obs = 0;
    for (int j = 301; j < 1190; j++) begin
      tx_valid = 1'b1;
      tx_data  = nxt;
      tx_datak = nxt[3:0];
      exp_rdy  = !(j >= 590 && ((j - 590) % 295) == 0);
      chk("data_ready", {31'h0, tx_ready}, {31'h0, exp_rdy});
      rdy = tx_ready;
      tick();
      if (indata === SKP) skp_obs++;
      if (!exp_rdy) begin
        chk_out("data_skp", SKP, 4'hF, 4'hF, 1'b1);
      end else begin
        chk_out("data_word", exp_word, exp_word[3:0], 4'h0, 1'b1);
        exp_word = exp_word + 32'd1;
      end
      if (rdy) nxt = nxt + 32'd1;
    end
    chk("skp_count", skp_obs, 32'd3);
    chk("accepted", nxt - BASE, 32'd886);

    // Logical idle, then scrambling disabled.
    tx_valid = 1'b0;
    chk("lidle_ready", {31'h0, tx_ready}, 32'h1);
    tick();
    chk_out("lidle", 32'h0, 4'h0, 4'h0, 1'b1);
    tick();
    chk_out("lidle2", 32'h0, 4'h0, 4'h0, 1'b1);
    scr_dis = 1'b1;
    tick();
    chk_out("lidle_scrdis", 32'h0, 4'h0, 4'h0, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 32'hCAFE_F00D;
    tx_datak = 4'b0010;
    tick();
    chk_out("data_scrdis", 32'hCAFE_F00D, 4'b0010, 4'h0, 1'b0);

    // Asynchronous reset in data mode.
    #3 rst = 1'b0;
    #1;
    chk_out("rst_data", 32'h0, 4'h0, 4'h0, 1'b0);
    chk("rst_data_ready", {31'h0, tx_ready}, 32'h0);
    mode = 2'b00; scr_dis = 1'b0; tx_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_out("post_rst_idle", 32'h0, 4'h0, 4'h0, 1'b0);
    mode = 2'b10;
    tick();
    chk_out("data_entry", 32'h0, 4'h0, 4'h0, 1'b0);
    // Counter restarted at 0: SKP exactly at data cycle 295.
    for (int j = 0; j <= 295; j++) begin
      chk("restart_ready", {31'h0, tx_ready}, {31'h0, (j != 295)});
      tick();
      if (j == 295) chk_out("restart_skp", SKP, 4'hF, 4'hF, 1'b1);
      else          chk_out("restart_idle", 32'h0, 4'h0, 4'h0, 1'b1);
    end

    // Back to training, reset mid ordered set.
    mode = 2'b01;
    chk("to_ts_ready", {31'h0, tx_ready}, 32'h1);
    tick();
    chk_out("to_ts_last_data", 32'h0, 4'h0, 4'h0, 1'b1);
    tick();
    chk_out("to_ts_w0", ts_word[0], ts_k[0], 4'hF, 1'b0);
    tick();
    chk_out("to_ts_w1", ts_word[1], ts_k[1], 4'hF, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk_out("rst_ts", 32'h0, 4'h0, 4'h0, 1'b0);
    chk("rst_ts_ready", {31'h0, tx_ready}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_out("ts_restart_entry", 32'h0, 4'h0, 4'h0, 1'b0);
    tick();
    chk_out("ts_restart_w0", ts_word[0], ts_k[0], 4'hF, 1'b0);
    tick();
    chk_out("ts_restart_w1", ts_word[1], ts_k[1], 4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
